// File: rtl/md_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package md_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL     = 2'd1,
      DIV     = 2'd2,
      DIV_FIX = 2'd3
   } md_state_t;

   localparam int DIV_ITERS = 32;

endpackage

// File: rtl/md_divider.sv
// Iterative unsigned 32/32 restoring divider, one quotient bit per cycle.
// o_last is high during the final iteration cycle; results are stable afterwards.
module md_divider
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic        o_last,
   output logic [31:0] o_quo,
   output logic [31:0] o_rem
);

   logic [31:0] r_quo;
   logic [31:0] r_rem;
   logic [31:0] r_dvs;
   logic [5:0]  r_cnt;
   logic        r_run;

   logic [32:0] w_shift;
   logic [32:0] w_diff;

   // The quotient register doubles as the dividend shift register.
   assign w_shift = {r_rem, r_quo[31]};
   assign w_diff  = w_shift - {1'b0, r_dvs};
   assign o_last  = r_run && (r_cnt == 6'(DIV_ITERS - 1));
   assign o_quo   = r_quo;
   assign o_rem   = r_rem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_quo <= '0;
         r_rem <= '0;
         r_dvs <= '0;
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (i_start) begin
         r_quo <= i_dividend;
         r_rem <= '0;
         r_dvs <= i_divisor;
         r_cnt <= '0;
         r_run <= 1'b1;
      end else if (r_run) begin
         if (!w_diff[32]) begin
            r_rem <= w_diff[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
         end else begin
            r_rem <= w_shift[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
         end
         r_cnt <= r_cnt + 6'd1;
         if (o_last) r_run <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning HI/LO; busy covers every cycle
// between acceptance and the HI/LO write of a multi-cycle operation.
module ex_muldiv
   import md_pkg::*;
#(
   parameter int MUL_LAT = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        md_valid,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_t   r_state, w_next;
   logic [31:0] r_hi, r_lo, r_rs;
   logic [63:0] r_prod;
   logic [3:0]  r_mcnt;
   logic        r_neg_q, r_neg_r, r_dz;

   md_op_t      w_op;
   logic        w_accept, w_is_mul, w_is_div, w_sdiv, w_last;
   logic [31:0] w_dvd_mag, w_dvs_mag, w_quo, w_rem, w_q_fix, w_r_fix;
   logic signed [63:0] w_prod_s;
   logic [63:0] w_prod_u;

   assign w_op     = md_op_t'(md_op);
   assign w_accept = md_valid && !flush && (r_state == IDLE);
   assign w_is_mul = (w_op == MD_MULT) || (w_op == MD_MULTU);
   assign w_is_div = (w_op == MD_DIV) || (w_op == MD_DIVU);
   assign w_sdiv   = (w_op == MD_DIV);

   assign w_prod_s  = $signed(rs_val) * $signed(rt_val);
   assign w_prod_u  = {32'd0, rs_val} * {32'd0, rt_val};
   assign w_dvd_mag = (w_sdiv && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
   assign w_dvs_mag = (w_sdiv && rt_val[31]) ? (32'd0 - rt_val) : rt_val;

   md_divider u_div (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_accept && w_is_div),
      .i_dividend (w_dvd_mag),
      .i_divisor  (w_dvs_mag),
      .o_last     (w_last),
      .o_quo      (w_quo),
      .o_rem      (w_rem)
   );

   assign w_q_fix = r_neg_q ? (32'd0 - w_quo) : w_quo;
   assign w_r_fix = r_neg_r ? (32'd0 - w_rem) : w_rem;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept && w_is_mul) w_next = MUL;
            else if (w_accept && w_is_div) w_next = DIV;
         end
         MUL:     if (r_mcnt == 4'(MUL_LAT)) w_next = IDLE;
         DIV:     if (w_last) w_next = DIV_FIX;
         DIV_FIX: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi    <= '0;
         r_lo    <= '0;
         r_rs    <= '0;
         r_prod  <= '0;
         r_mcnt  <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               if (w_op == MD_MTHI) r_hi <= rs_val;
               if (w_op == MD_MTLO) r_lo <= rs_val;
               if (w_is_mul) begin
                  r_prod <= (w_op == MD_MULT) ? w_prod_s : w_prod_u;
                  r_mcnt <= 4'd1;
               end
               if (w_is_div) begin
                  r_rs    <= rs_val;
                  r_neg_q <= w_sdiv && (rs_val[31] ^ rt_val[31]);
                  r_neg_r <= w_sdiv && rs_val[31];
                  r_dz    <= (rt_val == 32'd0);
               end
            end
            MUL: begin
               if (r_mcnt == 4'(MUL_LAT)) begin
                  r_hi <= r_prod[63:32];
                  r_lo <= r_prod[31:0];
               end else begin
                  r_mcnt <= r_mcnt + 4'd1;
               end
            end
            DIV_FIX: begin
               // Divide-by-zero returns all-ones quotient and the raw dividend.
               r_hi <= r_dz ? r_rs : w_r_fix;
               r_lo <= r_dz ? 32'hFFFF_FFFF : w_q_fix;
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != IDLE);
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv with hand-computed HI/LO results.
module tb_ex_muldiv;

   logic        clk;
   logic        rst;
   logic        md_valid;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_tests;
   int n_fail;

   ex_muldiv #(.MUL_LAT(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .md_valid (md_valid),
      .md_op    (md_op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .flush    (flush),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream protocol: no md instruction is presented while busy.
   always @(negedge clk) begin
      if (!rst && md_valid && busy) begin
         $display("FAIL protocol md_valid while busy at %0t", $time);
         n_fail++;
      end
   end

   // Present one op for one cycle, then count busy cycles (bounded).
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fl, output int nbusy);
      @(posedge clk); #1;
      md_valid = 1'b1; md_op = op; rs_val = a; rt_val = b; flush = fl;
      @(posedge clk); #1;
      md_valid = 1'b0; md_op = 3'd0; flush = 1'b0;
      nbusy = 0;
      while (busy && nbusy < 100) begin
         nbusy++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_fail++; end
      n_tests++;
      if (hi !== 32'h0) begin $display("FAIL reset_hi got %h want 0", hi); n_fail++; end
      n_tests++;
      if (lo !== 32'h0) begin $display("FAIL reset_lo got %h want 0", lo); n_fail++; end
   endtask

   task automatic test_mult();
      int nb;
      do_op(3'd1, 32'd7, 32'hFFFF_FFFD, 1'b0, nb);
      n_tests++;
      if (nb !== 5) begin $display("FAIL mult_busy got %0d want 5", nb); n_fail++; end
      n_tests++;
      if (hi !== 32'hFFFF_FFFF) begin $display("FAIL mult_hi got %h want ffffffff", hi); n_fail++; end
      n_tests++;
      if (lo !== 32'hFFFF_FFEB) begin $display("FAIL mult_lo got %h want ffffffeb", lo); n_fail++; end
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, nb);
      n_tests++;
      if (nb !== 5) begin $display("FAIL multu_busy got %0d want 5", nb); n_fail++; end
      n_tests++;
      if (hi !== 32'hFFFF_FFFE) begin $display("FAIL multu_hi got %h want fffffffe", hi); n_fail++; end
      n_tests++;
      if (lo !== 32'h0000_0001) begin $display("FAIL multu_lo got %h want 00000001", lo); n_fail++; end
   endtask

   task automatic test_div();
      int nb;
      do_op(3'd4, 32'd100, 32'd7, 1'b0, nb);
      n_tests++;
      if (nb !== 33) begin $display("FAIL divu_busy got %0d want 33", nb); n_fail++; end
      n_tests++;
      if (lo !== 32'h0000_000E) begin $display("FAIL divu_lo got %h want 0000000e", lo); n_fail++; end
      n_tests++;
      if (hi !== 32'h0000_0002) begin $display("FAIL divu_hi got %h want 00000002", hi); n_fail++; end
      do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, nb);
      n_tests++;
      if (lo !== 32'hFFFF_FFFD) begin $display("FAIL div_neg_lo got %h want fffffffd", lo); n_fail++; end
      n_tests++;
      if (hi !== 32'hFFFF_FFFF) begin $display("FAIL div_neg_hi got %h want ffffffff", hi); n_fail++; end
      do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb);
      n_tests++;
      if (lo !== 32'h8000_0000) begin $display("FAIL div_ovf_lo got %h want 80000000", lo); n_fail++; end
      n_tests++;
      if (hi !== 32'h0) begin $display("FAIL div_ovf_hi got %h want 00000000", hi); n_fail++; end
      do_op(3'd4, 32'd5, 32'd0, 1'b0, nb);
      n_tests++;
      if (nb !== 33) begin $display("FAIL divz_busy got %0d want 33", nb); n_fail++; end
      n_tests++;
      if (lo !== 32'hFFFF_FFFF) begin $display("FAIL divz_lo got %h want ffffffff", lo); n_fail++; end
      n_tests++;
      if (hi !== 32'd5) begin $display("FAIL divz_hi got %h want 00000005", hi); n_fail++; end
   endtask

   task automatic test_flush();
      int nb;
      // hi is 5 from the divide-by-zero case.
      do_op(3'd5, 32'h1234, 32'd0, 1'b1, nb);
      n_tests++;
      if (hi !== 32'd5) begin $display("FAIL mthi_flush_hi got %h want 00000005", hi); n_fail++; end
      n_tests++;
      if (nb !== 0) begin $display("FAIL mthi_flush_busy got %0d want 0", nb); n_fail++; end
      // flush after acceptance must not cancel the multiply
      @(posedge clk); #1;
      md_valid = 1'b1; md_op = 3'd1; rs_val = 32'd3; rt_val = 32'd5;
      @(posedge clk); #1;
      md_valid = 1'b0; md_op = 3'd0; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      nb = 0;
      while (busy && nb < 100) begin nb++; @(posedge clk); #1; end
      n_tests++;
      if (lo !== 32'd15) begin $display("FAIL mult_after_flush_lo got %h want 0000000f", lo); n_fail++; end
      n_tests++;
      if (hi !== 32'd0) begin $display("FAIL mult_after_flush_hi got %h want 00000000", hi); n_fail++; end
   endtask

   task automatic test_mtlo();
      int nb;
      do_op(3'd6, 32'hABCD, 32'd0, 1'b0, nb);
      n_tests++;
      if (lo !== 32'hABCD) begin $display("FAIL mtlo_lo got %h want 0000abcd", lo); n_fail++; end
      n_tests++;
      if (nb !== 0) begin $display("FAIL mtlo_busy got %0d want 0", nb); n_fail++; end
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      md_valid = 1'b1; md_op = 3'd5; rs_val = 32'h55;
      @(posedge clk); #1;
      md_op = 3'd6; rs_val = 32'h66;
      n_tests++;
      if (hi !== 32'h55) begin $display("FAIL b2b_hi got %h want 00000055", hi); n_fail++; end
      @(posedge clk); #1;
      md_valid = 1'b0; md_op = 3'd0;
      n_tests++;
      if (lo !== 32'h66) begin $display("FAIL b2b_lo got %h want 00000066", lo); n_fail++; end
      n_tests++;
      if (busy !== 1'b0) begin $display("FAIL b2b_busy got %b want 0", busy); n_fail++; end
   endtask

   task automatic test_async_reset();
      int nb;
      @(posedge clk); #1;
      md_valid = 1'b1; md_op = 3'd4; rs_val = 32'd1000; rt_val = 32'd3;
      @(posedge clk); #1;
      md_valid = 1'b0; md_op = 3'd0;
      for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
      n_tests++;
      if (busy !== 1'b1) begin $display("FAIL rst_pre_busy got %b want 1", busy); n_fail++; end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (busy !== 1'b0) begin $display("FAIL rst_async_busy got %b want 0", busy); n_fail++; end
      n_tests++;
      if (hi !== 32'h0) begin $display("FAIL rst_async_hi got %h want 0", hi); n_fail++; end
      n_tests++;
      if (lo !== 32'h0) begin $display("FAIL rst_async_lo got %h want 0", lo); n_fail++; end
      @(posedge clk); #1;
      rst = 1'b0;
      do_op(3'd1, 32'd3, 32'd4, 1'b0, nb);
      n_tests++;
      if (nb !== 5) begin $display("FAIL post_rst_busy got %0d want 5", nb); n_fail++; end
      n_tests++;
      if (lo !== 32'd12) begin $display("FAIL post_rst_lo got %h want 0000000c", lo); n_fail++; end
      n_tests++;
      if (hi !== 32'd0) begin $display("FAIL post_rst_hi got %h want 00000000", hi); n_fail++; end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1; md_valid = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      test_mult();
      test_div();
      test_flush();
      test_mtlo();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle multiply/divide unit inside the EX stage, directly upstream of the memory stage.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the architectural HI/LO registers.
- Exports `busy` to the stall-detect logic, which holds dependent instructions in ID.
- EX muxes `hi`/`lo` into EXout for MFHI/MFLO; that result then flows into the EX/MEM register.

Parameters:
- MUL_LAT, 5, number of busy cycles for MULT/MULTU (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- md_valid  in  1  EX holds an instruction with md_op != MD_NONE this cycle.
- md_op  in  3  operation code (md_pkg encoding).
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / MTHI-MTLO source).
- rt_val  in  32  forwarded rt operand (divisor / multiplier).
- flush  in  1  EX-stage flush from the controller; cancels the instruction in EX only.
- busy  out  1  operation in flight; HI/LO not yet valid.
- hi  out  32  committed HI register.
- lo  out  32  committed LO register.

Behaviour:
- Reset:
  - busy=0, hi=0, lo=0, FSM=IDLE, iteration counter=0, divider datapath registers=0.
  - Reset mid-operation aborts the operation; no partial HI/LO write occurs.
- Accept condition: md_valid & !flush & !busy in FSM=IDLE.
  - md_valid while busy is an upstream protocol violation (stall detect prevents it). The block ignores it; the bench asserts it never happens.
- MTHI/MTLO:
  - Accepted in cycle T; hi (or lo) = rs_val at end of T.
  - busy never asserts.
  - The value is readable in T+1.
- MULT/MULTU:
  - Accepted in cycle T; operands latched at end of T; state=MUL.
  - The signed (MULT) or unsigned (MULTU) 64-bit product is registered.
  - busy=1 for cycles T+1..T+MUL_LAT.
  - {hi,lo}=product written at the edge ending T+MUL_LAT; busy=0 and new values visible in T+MUL_LAT+1.
- DIV/DIVU:
  - Accepted in cycle T.
  - Restoring shift-subtract: 32 iterations in state DIV (one quotient bit per cycle), then 1 cycle in DIV_FIX.
  - busy=1 for exactly 33 cycles, T+1..T+33; hi/lo visible in T+34.
  - DIV uses operand magnitudes. The quotient is negated when operand signs differ. The remainder takes the dividend's sign.
  - Divisor 0, both DIV and DIVU: lo=0xFFFFFFFF, hi=rs_val. Full 33-cycle latency, no exception.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- FSM transitions:
  - IDLE->MUL on accepted mult.
  - IDLE->DIV on accepted div.
  - MUL->IDLE when the counter reaches MUL_LAT.
  - DIV->DIV_FIX after iteration 32.
  - DIV_FIX->IDLE.
- Flush:
  - flush blocks acceptance in the same cycle.
  - An already-accepted operation always completes; flush does not cancel it (architectural semantics).
- MFHI/MFLO:
  - No action in this block.
  - hi/lo outputs are purely registered; reading while busy returns the old value, so stall detect must stall any MFHI/MFLO/md instruction in ID while busy=1, or while EX holds an accepted mult/div.
- Counter widths: 4-bit MUL counter, 6-bit DIV counter; no wrap-around is reachable.

Decomposition:
- md_pkg:
  - md_op_t enum: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - FSM state enum IDLE/MUL/DIV/DIV_FIX.
  - DIV_ITERS=32 constant.
- One sub-module, md_divider:
  - Iterative unsigned 32/32 restoring divider with start/done.
  - ex_muldiv handles sign conversion, divide-by-zero and DIV_FIX correction.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIVU 100/7 -> busy 33 cycles; lo=0x0000000E, hi=0x00000002.
- DIV rs=0xFFFFFFF9, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, 33 busy cycles.
- MTHI 0x1234 with flush=1 -> hi unchanged.
- MTLO 0xABCD without flush -> lo=0xABCD next cycle, busy stays 0.
- DIV in progress, rst pulsed in busy cycle 10 -> busy=0, hi=lo=0 immediately (async).
- After rst, MULT 3*4 -> lo=12, hi=0 after normal latency.
